// File: rtl/jt6295_pkg.sv
// Shared constants for the jt6295 channel mixer: channel count, datapath widths
// and the OKI attenuation gain table (gain/32 per attenuation step).
package jt6295_pkg;

   localparam int NCH     = 4;   // channels per frame
   localparam int SNDW    = 12;  // decoder sample width
   localparam int GAINW   = 6;   // gain table entry width
   localparam int PRODW   = 18;  // raw sound*gain product width
   localparam int SHIFT   = 5;   // gain is a fixed-point fraction with 5 fractional bits
   localparam int SCALEDW = 13;  // scaled per-channel contribution width
   localparam int ACCW    = 14;  // frame accumulator width, four full-scale terms fit

   // Attenuation codes 0..8; anything above 8 is a mute.
   localparam logic [GAINW-1:0] GAIN_LUT [0:8] = '{
      6'd32, 6'd22, 6'd16, 6'd11, 6'd8, 6'd6, 6'd4, 6'd3, 6'd2
   };

   function automatic logic [GAINW-1:0] att_gain(input logic [3:0] att);
      logic [GAINW-1:0] g;
      case (att)
         4'd0:    g = GAIN_LUT[0];
         4'd1:    g = GAIN_LUT[1];
         4'd2:    g = GAIN_LUT[2];
         4'd3:    g = GAIN_LUT[3];
         4'd4:    g = GAIN_LUT[4];
         4'd5:    g = GAIN_LUT[5];
         4'd6:    g = GAIN_LUT[6];
         4'd7:    g = GAIN_LUT[7];
         4'd8:    g = GAIN_LUT[8];
         default: g = '0;
      endcase
      return g;
   endfunction

endpackage

// File: rtl/jt6295_mix_gain.sv
// Two-stage gain path: S1 registers the slot (sample forced to 0 when the
// channel is disabled), S2 registers (sound * gain) >>> 5 with floor rounding.
module jt6295_mix_gain
   import jt6295_pkg::*;
(
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic               cen_i,
   input  logic [1:0]         ch_i,
   input  logic               en_i,
   input  logic [3:0]         att_i,
   input  logic [SNDW-1:0]    sound_i,
   output logic [SCALEDW-1:0] scaled_o,
   output logic [1:0]         ch_o,
   output logic               vld_o
);

   logic [SNDW-1:0]    s1_sound_q, s1_sound_d;
   logic [GAINW-1:0]   s1_gain_q,  s1_gain_d;
   logic [1:0]         s1_ch_q;
   logic               s1_vld_q;
   logic [SCALEDW-1:0] s2_scaled_q;
   logic [1:0]         s2_ch_q;
   logic               s2_vld_q;
   logic [PRODW-1:0]   prod;

   // S1 next values: a disabled channel contributes a zero sample.
   always_comb begin
      s1_sound_d = en_i ? sound_i : '0;
      s1_gain_d  = att_gain(att_i);
   end

   // Both operands widened to the product width; the low 18 bits of the
   // unsigned product equal the two's-complement signed product.
   assign prod = {{(PRODW-SNDW){s1_sound_q[SNDW-1]}}, s1_sound_q}
               * {{(PRODW-GAINW){1'b0}}, s1_gain_q};

   // S1/S2 pipeline registers; the valid bits keep reset contents out of the mix.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         s1_sound_q  <= '0;
         s1_gain_q   <= '0;
         s1_ch_q     <= '0;
         s1_vld_q    <= 1'b0;
         s2_scaled_q <= '0;
         s2_ch_q     <= '0;
         s2_vld_q    <= 1'b0;
      end else if (cen_i) begin
         s1_sound_q  <= s1_sound_d;
         s1_gain_q   <= s1_gain_d;
         s1_ch_q     <= ch_i;
         s1_vld_q    <= 1'b1;
         s2_scaled_q <= prod[PRODW-1:SHIFT];
         s2_ch_q     <= s1_ch_q;
         s2_vld_q    <= s1_vld_q;
      end
   end

   assign scaled_o = s2_scaled_q;
   assign ch_o     = s2_ch_q;
   assign vld_o    = s2_vld_q;

endmodule

// File: rtl/jt6295_mix.sv
// Four-channel OKI mixer: scales each time-multiplexed channel sample by its
// attenuation gain, accumulates a frame from ch0 to ch3 and emits the
// (saturated or sign-extended) sum on mix with a one-clock sample strobe.
module jt6295_mix
   import jt6295_pkg::*;
#(
   parameter int OUTW = 14
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            cen,
   input  logic [1:0]      ch,
   input  logic            en,
   input  logic [3:0]      att,
   input  logic [11:0]     sound,
   output logic [OUTW-1:0] mix,
   output logic            sample
);

   logic [SCALEDW-1:0]     s2_scaled;
   logic [1:0]             s2_ch;
   logic                   s2_vld;
   logic signed [ACCW-1:0] scaled_ext, sum;
   logic signed [ACCW-1:0] acc_q, acc_d;
   logic                   started_q, started_d;
   logic [OUTW-1:0]        mix_q, mix_d;
   logic [OUTW-1:0]        sum_sat;
   logic                   emit;

   jt6295_mix_gain u_gain (
      .clk_i    (clk),
      .rst_ni   (rst_n),
      .cen_i    (cen),
      .ch_i     (ch),
      .en_i     (en),
      .att_i    (att),
      .sound_i  (sound),
      .scaled_o (s2_scaled),
      .ch_o     (s2_ch),
      .vld_o    (s2_vld)
   );

   assign scaled_ext = {s2_scaled[SCALEDW-1], s2_scaled};
   assign sum        = acc_q + scaled_ext;

   // Narrow outputs clamp; the native width or wider just sign-extends.
   if (OUTW < ACCW) begin : g_clamp
      localparam logic signed [ACCW-1:0] MAXV = ACCW'((1 << (OUTW-1)) - 1);
      localparam logic signed [ACCW-1:0] MINV = ~MAXV;
      // Clamp the frame sum into the output range.
      always_comb begin
         if (sum > MAXV)      sum_sat = MAXV[OUTW-1:0];
         else if (sum < MINV) sum_sat = MINV[OUTW-1:0];
         else                 sum_sat = sum[OUTW-1:0];
      end
   end else begin : g_extend
      assign sum_sat = OUTW'(sum);
   end

   // Frame accumulation: ch0 restarts, others add; ch3 publishes the frame.
   // Nothing is published until a ch0 has been seen since reset, so a frame
   // cut by reset never produces a partial sum.
   always_comb begin
      acc_d     = acc_q;
      started_d = started_q;
      mix_d     = mix_q;
      emit      = 1'b0;
      if (cen && s2_vld) begin
         if (s2_ch == 2'd0) begin
            acc_d     = scaled_ext;
            started_d = 1'b1;
         end else begin
            acc_d = sum;
         end
         if (s2_ch == 2'd3 && started_q) begin
            emit  = 1'b1;
            mix_d = sum_sat;
         end
      end
   end

   // Accumulator, frame-start flag and held output.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q     <= '0;
         started_q <= 1'b0;
         mix_q     <= '0;
      end else begin
         acc_q     <= acc_d;
         started_q <= started_d;
         mix_q     <= mix_d;
      end
   end

   assign mix    = mix_q;
   assign sample = emit;

endmodule

// File: tb/tb_jt6295_mix.sv
// Bench for jt6295_mix: two instances (OUTW=14 and OUTW=12) share stimulus.
// A slot-level reference model pushes expected frames (value and cen edge)
// when ch3 is driven; a monitor collects what the DUT emits.
`timescale 1ns/1ps
module tb_jt6295_mix;

   // ---------------- clock / reset / DUT ----------------
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        cen = 1'b0;
   logic [1:0]  ch = '0;
   logic        en = 1'b0;
   logic [3:0]  att = '0;
   logic [11:0] sound = '0;
   logic [13:0] mix14;
   logic [11:0] mix12;
   logic        sample14, sample12;

   always #5 clk = ~clk;

   jt6295_mix #(.OUTW(14)) dut14 (
      .clk(clk), .rst_n(rst_n), .cen(cen), .ch(ch), .en(en), .att(att),
      .sound(sound), .mix(mix14), .sample(sample14)
   );

   jt6295_mix #(.OUTW(12)) dut12 (
      .clk(clk), .rst_n(rst_n), .cen(cen), .ch(ch), .en(en), .att(att),
      .sound(sound), .mix(mix12), .sample(sample12)
   );

   // ---------------- scoreboard state ----------------
   int n_cmp = 0;
   int n_bad = 0;
   int cen_idx = 0;
   logic [13:0] exp14_q[$];
   logic [11:0] exp12_q[$];
   int          exp_edge_q[$];
   logic [13:0] obs14_q[$];
   logic [11:0] obs12_q[$];
   int          obs_edge_q[$];
   int  m_acc = 0;
   bit  m_started = 1'b0;
   int  gain_tab[16] = '{32, 22, 16, 11, 8, 6, 4, 3, 2, 0, 0, 0, 0, 0, 0, 0};
   logic [13:0] e14, o14, last14;
   logic [11:0] e12, o12, last12;
   int  ee, oe;
   logic pend = 1'b0;
   int  pend_edge = 0;

   // Monitor: sample must never pulse without cen; capture mix after an emit edge.
   always @(negedge clk) begin
      if (pend) begin
         obs14_q.push_back(mix14);
         obs12_q.push_back(mix12);
         obs_edge_q.push_back(pend_edge);
         pend = 1'b0;
      end
      n_cmp++;
      if (!cen) begin
         if (sample14 !== 1'b0 || sample12 !== 1'b0) begin
            n_bad++;
            $display("FAIL sample_without_cen: sample14=%b sample12=%b, required 0", sample14, sample12);
         end
      end else begin
         if (sample12 !== sample14) begin
            n_bad++;
            $display("FAIL sample_agree: sample12=%b, required %b", sample12, sample14);
         end
         if (sample14 === 1'b1) begin
            pend = 1'b1;
            pend_edge = cen_idx;
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- driver tasks ----------------
   // Drives one channel slot on a single cen edge (after gap idle clocks) and
   // updates the reference model. Entered and left at posedge+1.
   task automatic slot(input logic [1:0] c, input logic e, input logic [3:0] a,
                       input int s, input int gap);
      int p, con, sat;
      cen = 1'b0;
      repeat (gap) begin
         @(posedge clk);
         #1;
      end
      p   = e ? s * gain_tab[a] : 0;
      con = (p >= 0) ? p / 32 : -((-p + 31) / 32);
      if (c == 2'd0) begin
         m_acc = con;
         m_started = 1'b1;
      end else begin
         m_acc = m_acc + con;
      end
      if (c == 2'd3 && m_started) begin
         sat = (m_acc > 2047) ? 2047 : (m_acc < -2048) ? -2048 : m_acc;
         exp14_q.push_back(m_acc[13:0]);
         exp12_q.push_back(sat[11:0]);
         exp_edge_q.push_back(cen_idx + 2);
      end
      cen = 1'b1;
      ch = c;
      en = e;
      att = a;
      sound = s[11:0];
      @(posedge clk);
      #1;
      cen_idx++;
      cen = 1'b0;
   endtask

   task automatic frame(input int s0, input int s1, input int s2, input int s3,
                        input logic [3:0] a, input logic e, input bit gaps);
      slot(2'd0, e, a, s0, gaps ? int'($urandom_range(1, 5)) : 0);
      slot(2'd1, e, a, s1, gaps ? int'($urandom_range(1, 5)) : 0);
      slot(2'd2, e, a, s2, gaps ? int'($urandom_range(1, 5)) : 0);
      slot(2'd3, e, a, s3, gaps ? int'($urandom_range(1, 5)) : 0);
   endtask

   task automatic rand_frame(input bit gaps);
      for (int i = 0; i < 4; i++)
         slot(2'(i), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
              int'($urandom_range(0, 4095)) - 2048, gaps ? int'($urandom_range(1, 5)) : 0);
   endtask

   // Two silent slots push the last frame through the pipeline.
   task automatic flush();
      slot(2'd1, 1'b0, 4'd0, 0, 0);
      slot(2'd1, 1'b0, 4'd0, 0, 0);
      repeat (2) @(posedge clk);
      #1;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      repeat (3) @(posedge clk);
      #1;
      n_cmp++;
      if (mix14 !== 14'd0 || mix12 !== 12'd0 || sample14 !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_initial: mix14=%0d mix12=%0d sample=%b, required 0 0 0", mix14, mix12, sample14);
      end
      rst_n = 1'b1;
      frame(300, 300, 300, 300, 4'd0, 1'b1, 1'b0);
      flush();
      // partial frame cut by an asynchronous reset in mid-cycle
      slot(2'd0, 1'b1, 4'd0, 500, 0);
      slot(2'd1, 1'b1, 4'd0, 500, 0);
      #3;
      rst_n = 1'b0;
      m_acc = 0;
      m_started = 1'b0;
      #1;
      n_cmp++;
      if (mix14 !== 14'd0 || mix12 !== 12'd0 || sample14 !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_midframe: mix14=%0d mix12=%0d sample=%b, required 0 0 0", mix14, mix12, sample14);
      end
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      // tail of a frame with no ch0 since reset: must not emit
      slot(2'd2, 1'b1, 4'd0, 1000, 0);
      slot(2'd3, 1'b1, 4'd0, 1000, 0);
      for (int f = 0; f < 3; f++) frame(1000, 1000, 1000, 1000, 4'd0, 1'b1, 1'b0);
      flush();
      while (exp14_q.size() > 0) begin
         e14 = exp14_q.pop_front(); e12 = exp12_q.pop_front(); ee = exp_edge_q.pop_front();
         last14 = e14; last12 = e12;
         n_cmp++;
         if (obs14_q.size() == 0) begin
            n_bad++;
            $display("FAIL reset_frames: no sample, required mix=%0d at cen edge %0d", $signed(e14), ee);
         end else begin
            o14 = obs14_q.pop_front(); o12 = obs12_q.pop_front(); oe = obs_edge_q.pop_front();
            if (o14 !== e14 || o12 !== e12 || oe != ee) begin
               n_bad++;
               $display("FAIL reset_frames: mix14=%0d mix12=%0d edge=%0d, required %0d %0d %0d",
                        $signed(o14), $signed(o12), oe, $signed(e14), $signed(e12), ee);
            end
         end
      end
      n_cmp++;
      if (obs14_q.size() != 0) begin
         n_bad++;
         $display("FAIL reset_frames: %0d extra sample pulses, required 0", obs14_q.size());
         obs14_q.delete(); obs12_q.delete(); obs_edge_q.delete();
      end
   endtask

   task automatic test_gain_mix();
      slot(2'd0, 1'b1, 4'd2, 1000, 0);
      slot(2'd1, 1'b1, 4'd0, -1000, 0);
      slot(2'd2, 1'b1, 4'd8, 500, 0);
      slot(2'd3, 1'b1, 4'd15, 0, 0);
      for (int f = 0; f < 6; f++) rand_frame(1'b0);
      flush();
      while (exp14_q.size() > 0) begin
         e14 = exp14_q.pop_front(); e12 = exp12_q.pop_front(); ee = exp_edge_q.pop_front();
         last14 = e14; last12 = e12;
         n_cmp++;
         if (obs14_q.size() == 0) begin
            n_bad++;
            $display("FAIL gain_mix: no sample, required mix=%0d at cen edge %0d", $signed(e14), ee);
         end else begin
            o14 = obs14_q.pop_front(); o12 = obs12_q.pop_front(); oe = obs_edge_q.pop_front();
            if (o14 !== e14 || o12 !== e12 || oe != ee) begin
               n_bad++;
               $display("FAIL gain_mix: mix14=%0d mix12=%0d edge=%0d, required %0d %0d %0d",
                        $signed(o14), $signed(o12), oe, $signed(e14), $signed(e12), ee);
            end
         end
      end
      n_cmp++;
      if (obs14_q.size() != 0) begin
         n_bad++;
         $display("FAIL gain_mix: %0d extra sample pulses, required 0", obs14_q.size());
         obs14_q.delete(); obs12_q.delete(); obs_edge_q.delete();
      end
   endtask

   task automatic test_floor();
      slot(2'd0, 1'b1, 4'd1, -1, 0);
      for (int i = 1; i < 4; i++) slot(2'(i), 1'b0, 4'd0, 2047, 0);
      slot(2'd0, 1'b1, 4'd1, 1, 0);
      for (int i = 1; i < 4; i++) slot(2'(i), 1'b0, 4'd0, -2048, 0);
      slot(2'd0, 1'b1, 4'd8, -17, 0);
      slot(2'd1, 1'b1, 4'd3, -33, 0);
      slot(2'd2, 1'b1, 4'd9, 2047, 0);
      slot(2'd3, 1'b1, 4'd5, 7, 0);
      flush();
      while (exp14_q.size() > 0) begin
         e14 = exp14_q.pop_front(); e12 = exp12_q.pop_front(); ee = exp_edge_q.pop_front();
         last14 = e14; last12 = e12;
         n_cmp++;
         if (obs14_q.size() == 0) begin
            n_bad++;
            $display("FAIL floor: no sample, required mix=%0d at cen edge %0d", $signed(e14), ee);
         end else begin
            o14 = obs14_q.pop_front(); o12 = obs12_q.pop_front(); oe = obs_edge_q.pop_front();
            if (o14 !== e14 || o12 !== e12 || oe != ee) begin
               n_bad++;
               $display("FAIL floor: mix14=%0d mix12=%0d edge=%0d, required %0d %0d %0d",
                        $signed(o14), $signed(o12), oe, $signed(e14), $signed(e12), ee);
            end
         end
      end
      n_cmp++;
      if (obs14_q.size() != 0) begin
         n_bad++;
         $display("FAIL floor: %0d extra sample pulses, required 0", obs14_q.size());
         obs14_q.delete(); obs12_q.delete(); obs_edge_q.delete();
      end
   endtask

   task automatic test_saturation();
      frame(2047, 2047, 2047, 2047, 4'd0, 1'b1, 1'b0);
      frame(-2048, -2048, -2048, -2048, 4'd0, 1'b1, 1'b0);
      frame(2047, 2047, -2048, 100, 4'd0, 1'b1, 1'b0);
      flush();
      while (exp14_q.size() > 0) begin
         e14 = exp14_q.pop_front(); e12 = exp12_q.pop_front(); ee = exp_edge_q.pop_front();
         last14 = e14; last12 = e12;
         n_cmp++;
         if (obs14_q.size() == 0) begin
            n_bad++;
            $display("FAIL saturation: no sample, required mix=%0d at cen edge %0d", $signed(e14), ee);
         end else begin
            o14 = obs14_q.pop_front(); o12 = obs12_q.pop_front(); oe = obs_edge_q.pop_front();
            if (o14 !== e14 || o12 !== e12 || oe != ee) begin
               n_bad++;
               $display("FAIL saturation: mix14=%0d mix12=%0d edge=%0d, required %0d %0d %0d",
                        $signed(o14), $signed(o12), oe, $signed(e14), $signed(e12), ee);
            end
         end
      end
      n_cmp++;
      if (obs14_q.size() != 0) begin
         n_bad++;
         $display("FAIL saturation: %0d extra sample pulses, required 0", obs14_q.size());
         obs14_q.delete(); obs12_q.delete(); obs_edge_q.delete();
      end
   endtask

   task automatic test_cen_gaps();
      frame(2047, 2047, 2047, 2047, 4'd0, 1'b0, 1'b1);
      frame(1000, -1000, 500, 0, 4'd2, 1'b1, 1'b1);
      for (int f = 0; f < 4; f++) rand_frame(1'b1);
      flush();
      while (exp14_q.size() > 0) begin
         e14 = exp14_q.pop_front(); e12 = exp12_q.pop_front(); ee = exp_edge_q.pop_front();
         last14 = e14; last12 = e12;
         n_cmp++;
         if (obs14_q.size() == 0) begin
            n_bad++;
            $display("FAIL cen_gaps: no sample, required mix=%0d at cen edge %0d", $signed(e14), ee);
         end else begin
            o14 = obs14_q.pop_front(); o12 = obs12_q.pop_front(); oe = obs_edge_q.pop_front();
            if (o14 !== e14 || o12 !== e12 || oe != ee) begin
               n_bad++;
               $display("FAIL cen_gaps: mix14=%0d mix12=%0d edge=%0d, required %0d %0d %0d",
                        $signed(o14), $signed(o12), oe, $signed(e14), $signed(e12), ee);
            end
         end
      end
      n_cmp++;
      if (obs14_q.size() != 0) begin
         n_bad++;
         $display("FAIL cen_gaps: %0d extra sample pulses, required 0", obs14_q.size());
         obs14_q.delete(); obs12_q.delete(); obs_edge_q.delete();
      end
   endtask

   task automatic test_order();
      int seq_a[7] = '{0, 1, 2, 3, 0, 1, 3};
      int seq_b[4] = '{0, 1, 2, 0};
      int seq_c[7] = '{1, 2, 3, 0, 1, 1, 3};
      int val[4] = '{100, 200, 400, 800};
      for (int i = 0; i < 7; i++) slot(2'(seq_a[i]), 1'b1, 4'd0, val[seq_a[i]], 0);
      flush();
      for (int i = 0; i < 4; i++) slot(2'(seq_b[i]), 1'b1, 4'd0, val[seq_b[i]], 0);
      flush();
      while (exp14_q.size() > 0) begin
         e14 = exp14_q.pop_front(); e12 = exp12_q.pop_front(); ee = exp_edge_q.pop_front();
         last14 = e14; last12 = e12;
         n_cmp++;
         if (obs14_q.size() == 0) begin
            n_bad++;
            $display("FAIL order: no sample, required mix=%0d at cen edge %0d", $signed(e14), ee);
         end else begin
            o14 = obs14_q.pop_front(); o12 = obs12_q.pop_front(); oe = obs_edge_q.pop_front();
            if (o14 !== e14 || o12 !== e12 || oe != ee) begin
               n_bad++;
               $display("FAIL order: mix14=%0d mix12=%0d edge=%0d, required %0d %0d %0d",
                        $signed(o14), $signed(o12), oe, $signed(e14), $signed(e12), ee);
            end
         end
      end
      n_cmp++;
      if (obs14_q.size() != 0) begin
         n_bad++;
         $display("FAIL order: %0d extra sample pulses, required 0", obs14_q.size());
         obs14_q.delete(); obs12_q.delete(); obs_edge_q.delete();
      end
      // frame without ch3: output holds the last emitted value
      n_cmp++;
      if (mix14 !== last14 || mix12 !== last12) begin
         n_bad++;
         $display("FAIL order_hold: mix14=%0d mix12=%0d, required %0d %0d",
                  $signed(mix14), $signed(mix12), $signed(last14), $signed(last12));
      end
      // skipped ch0 keeps accumulating; repeated ch1 counts twice
      for (int i = 0; i < 7; i++) slot(2'(seq_c[i]), 1'b1, 4'd0, val[seq_c[i]], 0);
      flush();
      while (exp14_q.size() > 0) begin
         e14 = exp14_q.pop_front(); e12 = exp12_q.pop_front(); ee = exp_edge_q.pop_front();
         last14 = e14; last12 = e12;
         n_cmp++;
         if (obs14_q.size() == 0) begin
            n_bad++;
            $display("FAIL order_skip: no sample, required mix=%0d at cen edge %0d", $signed(e14), ee);
         end else begin
            o14 = obs14_q.pop_front(); o12 = obs12_q.pop_front(); oe = obs_edge_q.pop_front();
            if (o14 !== e14 || o12 !== e12 || oe != ee) begin
               n_bad++;
               $display("FAIL order_skip: mix14=%0d mix12=%0d edge=%0d, required %0d %0d %0d",
                        $signed(o14), $signed(o12), oe, $signed(e14), $signed(e12), ee);
            end
         end
      end
      n_cmp++;
      if (obs14_q.size() != 0) begin
         n_bad++;
         $display("FAIL order_skip: %0d extra sample pulses, required 0", obs14_q.size());
         obs14_q.delete(); obs12_q.delete(); obs_edge_q.delete();
      end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      test_reset();
      test_gain_mix();
      test_floor();
      test_saturation();
      test_cen_gaps();
      test_order();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
